// File: rtl/match_sequencer.sv
// Match-level controller for pong: decodes PS/2 start/pause/reset keys and
// sequences the match through idle, serve, play, point-pause and game-over.
module match_sequencer #(
    parameter int         WIN_SCORE   = 7,
    parameter int         SERVE_TICKS = 48,
    parameter int         POINT_TICKS = 32,
    parameter logic [7:0] KEY_START   = 8'h29,
    parameter logic [7:0] KEY_PAUSE   = 8'h4D,
    parameter logic [7:0] KEY_RESET   = 8'h2D
) (
    input  logic       CLOCK_50,
    input  logic       rst_n,
    input  logic       move_tick,
    input  logic [7:0] scan_code,
    input  logic       scan_ready,
    input  logic       left_point,
    input  logic       right_point,
    output logic       ball_run,
    output logic       ball_reset,
    output logic       serve_dir,
    output logic [2:0] scoreL,
    output logic [2:0] scoreR,
    output logic       game_over,
    output logic       left_win,
    output logic       right_win,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_POINT = 3'd3,
        S_PAUSE = 3'd4,
        S_OVER  = 3'd5
    } state_t;

    localparam logic [2:0] WIN = 3'(WIN_SCORE);

    state_t     state, state_nx;
    logic [7:0] countdown, countdown_nx;
    logic [2:0] score_l_nx, score_r_nx, score_l_inc, score_r_inc;
    logic       serve_dir_nx, left_win_nx, right_win_nx;
    logic       ball_run_nx, ball_reset_nx, game_over_nx;
    logic       break_flag, break_nx;
    logic       scan_ready_q, left_point_q, right_point_q;
    logic       key_event, make_valid, make_start, make_pause, make_reset;
    logic       left_edge, right_edge;

    assign key_event  = scan_ready & ~scan_ready_q;
    assign left_edge  = left_point & ~left_point_q;
    assign right_edge = right_point & ~right_point_q;

    assign score_l_inc = (scoreL >= WIN) ? scoreL : scoreL + 3'd1;
    assign score_r_inc = (scoreR >= WIN) ? scoreR : scoreR + 3'd1;

    // E0 prefixes are transparent; after F0 the following byte is a release.
    always_comb begin
        break_nx   = break_flag;
        make_valid = 1'b0;
        if (key_event && scan_code != 8'hE0) begin
            if (break_flag)
                break_nx = 1'b0;
            else if (scan_code == 8'hF0)
                break_nx = 1'b1;
            else
                make_valid = 1'b1;
        end
    end

    assign make_start = make_valid && (scan_code == KEY_START);
    assign make_pause = make_valid && (scan_code == KEY_PAUSE);
    assign make_reset = make_valid && (scan_code == KEY_RESET);

    always_comb begin
        state_nx      = state;
        countdown_nx  = countdown;
        score_l_nx    = scoreL;
        score_r_nx    = scoreR;
        serve_dir_nx  = serve_dir;
        left_win_nx   = left_win;
        right_win_nx  = right_win;
        ball_run_nx   = 1'b0;
        ball_reset_nx = 1'b1;
        game_over_nx  = 1'b0;

        case (state)
            S_IDLE: begin
                if (make_start) begin
                    state_nx     = S_SERVE;
                    countdown_nx = 8'(SERVE_TICKS);
                end
            end
            S_SERVE: begin
                if (countdown == 8'd0)
                    state_nx = S_PLAY;
                else if (move_tick)
                    countdown_nx = countdown - 8'd1;
            end
            S_PLAY: begin
                // A point beats a simultaneous pause; left beats right.
                if (left_edge) begin
                    score_l_nx   = score_l_inc;
                    serve_dir_nx = 1'b1;
                    if (score_l_inc == WIN) begin
                        state_nx    = S_OVER;
                        left_win_nx = 1'b1;
                    end else begin
                        state_nx     = S_POINT;
                        countdown_nx = 8'(POINT_TICKS);
                    end
                end else if (right_edge) begin
                    score_r_nx   = score_r_inc;
                    serve_dir_nx = 1'b0;
                    if (score_r_inc == WIN) begin
                        state_nx     = S_OVER;
                        right_win_nx = 1'b1;
                    end else begin
                        state_nx     = S_POINT;
                        countdown_nx = 8'(POINT_TICKS);
                    end
                end else if (make_pause) begin
                    state_nx = S_PAUSE;
                end
            end
            S_POINT: begin
                if (countdown == 8'd0) begin
                    state_nx     = S_SERVE;
                    countdown_nx = 8'(SERVE_TICKS);
                end else if (move_tick) begin
                    countdown_nx = countdown - 8'd1;
                end
            end
            S_PAUSE: begin
                if (make_pause)
                    state_nx = S_PLAY;
            end
            S_OVER: begin
                if (make_start) begin
                    state_nx     = S_SERVE;
                    countdown_nx = 8'(SERVE_TICKS);
                    score_l_nx   = 3'd0;
                    score_r_nx   = 3'd0;
                    left_win_nx  = 1'b0;
                    right_win_nx = 1'b0;
                end
            end
            default: state_nx = S_IDLE;
        endcase

        if (make_reset) begin
            state_nx     = S_IDLE;
            countdown_nx = 8'd0;
            score_l_nx   = 3'd0;
            score_r_nx   = 3'd0;
            serve_dir_nx = 1'b0;
            left_win_nx  = 1'b0;
            right_win_nx = 1'b0;
        end

        // Ball control is decoded from the next state so it registers with it.
        case (state_nx)
            S_PLAY: begin
                ball_run_nx   = 1'b1;
                ball_reset_nx = 1'b0;
            end
            S_PAUSE: ball_reset_nx = 1'b0;
            S_OVER:  game_over_nx  = 1'b1;
            default: ball_reset_nx = 1'b1;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            scan_ready_q  <= 1'b0;
            left_point_q  <= 1'b0;
            right_point_q <= 1'b0;
        end else begin
            scan_ready_q  <= scan_ready;
            left_point_q  <= left_point;
            right_point_q <= right_point;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            countdown  <= 8'd0;
            scoreL     <= 3'd0;
            scoreR     <= 3'd0;
            serve_dir  <= 1'b0;
            left_win   <= 1'b0;
            right_win  <= 1'b0;
            break_flag <= 1'b0;
            ball_run   <= 1'b0;
            ball_reset <= 1'b1;
            game_over  <= 1'b0;
        end else begin
            state      <= state_nx;
            countdown  <= countdown_nx;
            scoreL     <= score_l_nx;
            scoreR     <= score_r_nx;
            serve_dir  <= serve_dir_nx;
            left_win   <= left_win_nx;
            right_win  <= right_win_nx;
            break_flag <= break_nx;
            ball_run   <= ball_run_nx;
            ball_reset <= ball_reset_nx;
            game_over  <= game_over_nx;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_match_sequencer.sv
// Directed bench for match_sequencer with short serve/point countdowns and
// a three-point match; inputs change and outputs are checked on the falling edge.
module tb_match_sequencer;

    localparam logic [2:0] IDLE = 3'd0, SERVE = 3'd1, PLAY = 3'd2,
                           POINT = 3'd3, PAUSE = 3'd4, OVER = 3'd5;

    logic       CLOCK_50 = 1'b0;
    logic       rst_n = 1'b0;
    logic       move_tick = 1'b0;
    logic [7:0] scan_code = 8'h00;
    logic       scan_ready = 1'b0;
    logic       left_point = 1'b0;
    logic       right_point = 1'b0;
    logic       ball_run, ball_reset, serve_dir, game_over, left_win, right_win;
    logic [2:0] scoreL, scoreR, state_o;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int ticks_seen = 0;

    match_sequencer #(
        .WIN_SCORE(3),
        .SERVE_TICKS(4),
        .POINT_TICKS(2)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .rst_n(rst_n),
        .move_tick(move_tick),
        .scan_code(scan_code),
        .scan_ready(scan_ready),
        .left_point(left_point),
        .right_point(right_point),
        .ball_run(ball_run),
        .ball_reset(ball_reset),
        .serve_dir(serve_dir),
        .scoreL(scoreL),
        .scoreR(scoreR),
        .game_over(game_over),
        .left_win(left_win),
        .right_win(right_win),
        .state_o(state_o)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // The tick set at the previous falling edge is consumed by the state
    // visible during that cycle, so it is tallied before advancing.
    task automatic nextCycle();
        if (move_tick)
            ticks_seen++;
        @(negedge CLOCK_50);
        cyc++;
        move_tick = (cyc % 4 == 0);
    endtask

    task automatic applyStimulus(input logic [7:0] code);
        scan_code  = code;
        scan_ready = 1'b1;
        nextCycle();
        scan_ready = 1'b0;
    endtask

    task automatic runUntil(input logic [2:0] target, input int budget);
        for (int i = 0; i < budget && state_o !== target; i++)
            nextCycle();
    endtask

    task automatic pulsePoint(input logic left);
        left_point  = left;
        right_point = ~left;
        nextCycle();
        left_point  = 1'b0;
        right_point = 1'b0;
    endtask

    task automatic rallyToPlay();
        ticks_seen = 0;
        runUntil(SERVE, 40);
        checkOutput("point_to_serve", {5'd0, state_o}, {5'd0, SERVE});
        checkOutput("point_ticks", 8'(ticks_seen), 8'd2);
        ticks_seen = 0;
        runUntil(PLAY, 60);
        checkOutput("serve_to_play", {5'd0, state_o}, {5'd0, PLAY});
        checkOutput("serve_ticks", 8'(ticks_seen), 8'd4);
    endtask

    initial begin
        nextCycle();
        nextCycle();
        checkOutput("rst_state", {5'd0, state_o}, {5'd0, IDLE});
        checkOutput("rst_ball_reset", {7'd0, ball_reset}, 8'd1);
        checkOutput("rst_ball_run", {7'd0, ball_run}, 8'd0);
        checkOutput("rst_scores", {2'd0, scoreL, scoreR}, 8'd0);
        rst_n = 1'b1;
        nextCycle();
        checkOutput("idle_after_rst", {5'd0, state_o}, {5'd0, IDLE});

        applyStimulus(8'h29);
        checkOutput("start_serve", {5'd0, state_o}, {5'd0, SERVE});
        checkOutput("serve_ball_reset", {7'd0, ball_reset}, 8'd1);
        ticks_seen = 0;
        runUntil(PLAY, 60);
        checkOutput("first_play", {5'd0, state_o}, {5'd0, PLAY});
        checkOutput("first_serve_ticks", 8'(ticks_seen), 8'd4);
        checkOutput("play_ball_run", {6'd0, ball_run, ball_reset}, 8'b10);

        left_point = 1'b1;
        nextCycle();
        checkOutput("lpt_state", {5'd0, state_o}, {5'd0, POINT});
        checkOutput("lpt_scoreL", {5'd0, scoreL}, 8'd1);
        checkOutput("lpt_dir", {7'd0, serve_dir}, 8'd1);
        ticks_seen = 0;
        nextCycle();
        left_point = 1'b0;
        checkOutput("lpt_held_once", {5'd0, scoreL}, 8'd1);
        runUntil(SERVE, 40);
        checkOutput("lpt_to_serve", {5'd0, state_o}, {5'd0, SERVE});
        checkOutput("lpt_point_ticks", 8'(ticks_seen), 8'd2);
        ticks_seen = 0;
        runUntil(PLAY, 60);
        checkOutput("lpt_to_play", {5'd0, state_o}, {5'd0, PLAY});
        checkOutput("lpt_serve_ticks", 8'(ticks_seen), 8'd4);

        for (int n = 1; n <= 2; n++) begin
            pulsePoint(1'b0);
            checkOutput("rpt_state", {5'd0, state_o}, {5'd0, POINT});
            checkOutput("rpt_scoreR", {5'd0, scoreR}, 8'(n));
            checkOutput("rpt_dir", {7'd0, serve_dir}, 8'd0);
            rallyToPlay();
        end
        pulsePoint(1'b0);
        checkOutput("win_state", {5'd0, state_o}, {5'd0, OVER});
        checkOutput("win_scoreR", {5'd0, scoreR}, 8'd3);
        checkOutput("win_flags", {5'd0, game_over, left_win, right_win}, 8'b101);
        checkOutput("win_ball_reset", {7'd0, ball_reset}, 8'd1);
        nextCycle();
        pulsePoint(1'b0);
        checkOutput("over_saturate", {2'd0, scoreL, scoreR}, {2'd0, 3'd1, 3'd3});
        checkOutput("over_stays", {5'd0, state_o}, {5'd0, OVER});
        applyStimulus(8'h29);
        checkOutput("restart_state", {5'd0, state_o}, {5'd0, SERVE});
        checkOutput("restart_clear", {2'd0, scoreL, scoreR}, 8'd0);
        checkOutput("restart_flags", {5'd0, game_over, left_win, right_win}, 8'd0);
        nextCycle();

        applyStimulus(8'h2D);
        checkOutput("rkey_idle", {5'd0, state_o}, {5'd0, IDLE});
        nextCycle();
        applyStimulus(8'hF0);
        nextCycle();
        applyStimulus(8'h29);
        checkOutput("break_ignored", {5'd0, state_o}, {5'd0, IDLE});
        nextCycle();
        applyStimulus(8'h29);
        checkOutput("make_after_break", {5'd0, state_o}, {5'd0, SERVE});
        runUntil(PLAY, 60);
        checkOutput("pause_setup", {5'd0, state_o}, {5'd0, PLAY});
        scan_code  = 8'h4D;
        scan_ready = 1'b1;
        nextCycle();
        checkOutput("pause_state", {5'd0, state_o}, {5'd0, PAUSE});
        checkOutput("pause_ball", {6'd0, ball_run, ball_reset}, 8'b00);
        nextCycle();
        nextCycle();
        scan_ready = 1'b0;
        checkOutput("pause_level_once", {5'd0, state_o}, {5'd0, PAUSE});
        pulsePoint(1'b1);
        checkOutput("pause_ignores_pt", {2'd0, scoreL, scoreR}, 8'd0);
        applyStimulus(8'h4D);
        checkOutput("unpause", {5'd0, state_o}, {5'd0, PLAY});
        checkOutput("unpause_run", {7'd0, ball_run}, 8'd1);
        nextCycle();

        left_point  = 1'b1;
        right_point = 1'b1;
        nextCycle();
        left_point  = 1'b0;
        right_point = 1'b0;
        checkOutput("both_left_wins", {2'd0, scoreL, scoreR}, {2'd0, 3'd1, 3'd0});
        checkOutput("both_dir", {7'd0, serve_dir}, 8'd1);
        rallyToPlay();
        right_point = 1'b1;
        scan_code   = 8'h4D;
        scan_ready  = 1'b1;
        nextCycle();
        right_point = 1'b0;
        scan_ready  = 1'b0;
        checkOutput("pt_beats_pause", {5'd0, state_o}, {5'd0, POINT});
        checkOutput("pt_beats_pause_sc", {5'd0, scoreR}, 8'd1);
        rallyToPlay();
        pulsePoint(1'b1);
        runUntil(SERVE, 40);
        nextCycle();
        checkOutput("mid_serve_setup", {2'd0, scoreL, scoreR}, {2'd0, 3'd2, 3'd1});
        applyStimulus(8'h2D);
        checkOutput("rkey_serve_idle", {5'd0, state_o}, {5'd0, IDLE});
        checkOutput("rkey_scores", {2'd0, scoreL, scoreR}, 8'd0);
        checkOutput("rkey_dir", {6'd0, serve_dir, ball_reset}, 8'b01);
        nextCycle();

        applyStimulus(8'h29);
        runUntil(PLAY, 60);
        pulsePoint(1'b1);
        nextCycle();
        checkOutput("pre_async_state", {5'd0, state_o}, {5'd0, POINT});
        rst_n = 1'b0;
        #1;
        checkOutput("async_state", {5'd0, state_o}, {5'd0, IDLE});
        checkOutput("async_scores", {2'd0, scoreL, scoreR}, 8'd0);
        checkOutput("async_ctrl", {3'd0, ball_run, ball_reset, serve_dir, game_over, left_win | right_win}, 8'b01000);
        nextCycle();
        rst_n = 1'b1;
        nextCycle();
        checkOutput("post_async_idle", {5'd0, state_o}, {5'd0, IDLE});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
